// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 active-low keypad, debounces whole frames and
// drives a one-hot key code. Define KEYSCAN_REPEAT_EN to add auto-repeat key_event pulses.
module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 5,
  parameter int REPEAT_FRAMES  = 125
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_event
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STABLE_ONE = SW'(1);
  localparam logic [SW-1:0] STABLE_ZERO = SW'(0);

  if ((SCAN_DIV < 4) || (DEBOUNCE_SCANS < 1) || (REPEAT_FRAMES < 1)) begin : g_bad_params
    $error("keypad_scan_encoder: SCAN_DIV >= 4, DEBOUNCE_SCANS >= 1, REPEAT_FRAMES >= 1 required");
  end

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    logic [3:0] drv;
    case (r)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1111;
    endcase
    return drv;
  endfunction

  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // More than one closed contact (or ghosting) is rejected as "no key".
  function automatic logic [15:0] form_candidate(input logic [15:0] frame);
    logic [15:0] cand;
    if (count_ones(frame) == 5'd1) begin
      cand = frame;
    end else begin
      cand = 16'd0;
    end
    return cand;
  endfunction

  logic [3:0]    col_meta_q, col_meta_d;
  logic [3:0]    col_sync_q, col_sync_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    row_out_q, row_out_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   prev_cand_q, prev_cand_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [15:0]   onehot_q, onehot_d;
  logic          key_valid_q, key_valid_d;
  logic          key_event_q, key_event_d;
  logic          sample_s;
  logic          frame_end_s;
  logic [15:0]   cand_s;

`ifdef KEYSCAN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);
  localparam logic [RW-1:0] REP_ZERO = RW'(0);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Two-flop synchronizer for the asynchronous column lines.
  always_comb begin
    col_meta_d = col_in;
    col_sync_d = col_meta_q;
  end

  // Frame-end candidate includes the row-3 bits being captured this very cycle.
  always_comb begin
    sample_s    = (dwell_q == DWELL_LAST);
    frame_end_s = sample_s && (row_q == 2'd3);
    cand_s      = form_candidate({~col_sync_q, snap_q[11:0]});
  end

  // Row dwell counter, row advance and per-row snapshot capture.
  always_comb begin
    dwell_d   = dwell_q;
    row_d     = row_q;
    row_out_d = row_out_q;
    snap_d    = snap_q;
    if (sample_s) begin
      dwell_d   = DWELL_ZERO;
      row_d     = row_q + 2'd1;
      row_out_d = row_drive(row_d);
      snap_d[{row_q, 2'b00} +: 4] = ~col_sync_q;
    end else begin
      dwell_d = dwell_q + DWELL_ONE;
    end
  end

  // Frame debounce, output update and optional auto-repeat.
  always_comb begin
    prev_cand_d  = prev_cand_q;
    stable_cnt_d = stable_cnt_q;
    onehot_d     = onehot_q;
    key_valid_d  = key_valid_q;
    key_event_d  = 1'b0;
`ifdef KEYSCAN_REPEAT_EN
    rep_cnt_d    = rep_cnt_q;
`endif
    if (frame_end_s) begin
      if (cand_s == prev_cand_q) begin
        if (stable_cnt_q < STABLE_MAX) begin
          stable_cnt_d = stable_cnt_q + STABLE_ONE;
        end else begin
          stable_cnt_d = STABLE_MAX;
        end
      end else begin
        stable_cnt_d = STABLE_ONE;
      end
      prev_cand_d = cand_s;
      if ((stable_cnt_d >= STABLE_MAX) && (cand_s != onehot_q)) begin
        onehot_d    = cand_s;
        key_valid_d = (cand_s != 16'd0);
        key_event_d = (cand_s != 16'd0);
      end else begin
        onehot_d = onehot_q;
      end
`ifdef KEYSCAN_REPEAT_EN
      // A code change restarts the repeat interval; a held key pulses every REPEAT_FRAMES.
      if (onehot_d != onehot_q) begin
        rep_cnt_d = REP_ZERO;
      end else if (onehot_q != 16'd0) begin
        if (rep_cnt_q >= REP_LAST) begin
          rep_cnt_d   = REP_ZERO;
          key_event_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_ONE;
        end
      end else begin
        rep_cnt_d = REP_ZERO;
      end
`endif
    end else begin
      prev_cand_d = prev_cand_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      col_meta_q   <= 4'hF;
      col_sync_q   <= 4'hF;
      dwell_q      <= DWELL_ZERO;
      row_q        <= 2'd0;
      row_out_q    <= 4'b1110;
      snap_q       <= 16'd0;
      prev_cand_q  <= 16'd0;
      stable_cnt_q <= STABLE_ZERO;
      onehot_q     <= 16'd0;
      key_valid_q  <= 1'b0;
      key_event_q  <= 1'b0;
`ifdef KEYSCAN_REPEAT_EN
      rep_cnt_q    <= REP_ZERO;
`endif
    end else begin
      col_meta_q   <= col_meta_d;
      col_sync_q   <= col_sync_d;
      dwell_q      <= dwell_d;
      row_q        <= row_d;
      row_out_q    <= row_out_d;
      snap_q       <= snap_d;
      prev_cand_q  <= prev_cand_d;
      stable_cnt_q <= stable_cnt_d;
      onehot_q     <= onehot_d;
      key_valid_q  <= key_valid_d;
      key_event_q  <= key_event_d;
`ifdef KEYSCAN_REPEAT_EN
      rep_cnt_q    <= rep_cnt_d;
`endif
    end
  end

  assign row_out   = row_out_q;
  assign onehot    = onehot_q;
  assign key_valid = key_valid_q;
  assign key_event = key_event_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder: SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_FRAMES=4 (16-cycle frames).
module tb_keypad_scan_encoder;

`ifdef KEYSCAN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_event;
  logic [15:0] keys;

  int n_total = 0;
  int n_pass  = 0;
  int ev_cnt  = 0;
  int ev_base = 0;
  logic ev_prev  = 1'b0;
  logic dbl_seen = 1'b0;

  keypad_scan_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_FRAMES(4)) dut (
    .clk      (clk),
    .RST      (RST),
    .col_in   (col_in),
    .row_out  (row_out),
    .onehot   (onehot),
    .key_valid(key_valid),
    .key_event(key_event)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its column to the driven-low row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && keys[4*r+c]) col_in[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (key_event) ev_cnt <= ev_cnt + 1;
    if (key_event && ev_prev) dbl_seen <= 1'b1;
    ev_prev <= key_event;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic frames(input int n);
    repeat (16 * n) @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] one_bit;
    logic [3:0] exp_row;
    logic [15:0] exp_oh;
    logic exp_ev;
    int exp_rep;
    one_bit = 4'b0001;
    RST  = 1'b1;
    keys = 16'h0000;
    cyc(3);
    RST = 1'b0;
    check_eq("rst_row_out", {28'd0, row_out}, 32'h0000_000E);
    check_eq("rst_onehot", {16'd0, onehot}, 32'h0);
    check_eq("rst_valid", {31'd0, key_valid}, 32'h0);
    check_eq("rst_event", {31'd0, key_event}, 32'h0);

    // Idle scan: each row held low for 4 cycles
    for (int k = 0; k < 16; k++) begin
      exp_row = ~(one_bit << (k / 4));
      check_eq("row_walk", {28'd0, row_out}, {28'd0, exp_row});
      cyc(1);
    end
    check_eq("idle_onehot", {16'd0, onehot}, 32'h0);
    check_eq("idle_valid", {31'd0, key_valid}, 32'h0);

    // Single press (1,3) aligned to frame start
    keys = 16'h0080;
    ev_base = ev_cnt;
    frames(2);
    check_eq("press_early", {16'd0, onehot}, 32'h0);
    frames(1);
    check_eq("press_onehot", {16'd0, onehot}, 32'h0080);
    check_eq("press_valid", {31'd0, key_valid}, 32'h1);
    check_eq("press_event", {31'd0, key_event}, 32'h1);
    cyc(1);
    check_eq("press_event_end", {31'd0, key_event}, 32'h0);
    cyc(15);
    check_eq("press_events", ev_cnt - ev_base, 32'd1);

    // Release, then press (2,1)
    keys = 16'h0000;
    ev_base = ev_cnt;
    frames(2);
    check_eq("release_early", {16'd0, onehot}, 32'h0080);
    frames(1);
    check_eq("release_onehot", {16'd0, onehot}, 32'h0);
    check_eq("release_valid", {31'd0, key_valid}, 32'h0);
    check_eq("release_event", {31'd0, key_event}, 32'h0);
    keys = 16'h0200;
    frames(3);
    check_eq("change_onehot", {16'd0, onehot}, 32'h0200);
    check_eq("change_event", {31'd0, key_event}, 32'h1);
    check_eq("release_events", ev_cnt - ev_base, 32'd0);
    ev_base = ev_cnt;
    frames(1);
    check_eq("change_events", ev_cnt - ev_base, 32'd1);
    keys = 16'h0000;
    frames(3);
    check_eq("release2_onehot", {16'd0, onehot}, 32'h0);

    // Bounce: (0,0) toggling every frame never becomes stable
    ev_base = ev_cnt;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      frames(1);
      check_eq("bounce_onehot", {16'd0, onehot}, 32'h0);
    end
    keys = 16'h0000;
    check_eq("bounce_events", ev_cnt - ev_base, 32'd0);

    // Multi-press (0,1)+(3,2) rejected
    keys = 16'h4002;
    frames(4);
    check_eq("multi_onehot", {16'd0, onehot}, 32'h0);
    check_eq("multi_valid", {31'd0, key_valid}, 32'h0);

    // (3,2) alone, then reset mid-frame while held
    keys = 16'h4000;
    frames(3);
    check_eq("k32_onehot", {16'd0, onehot}, 32'h4000);
    check_eq("k32_event", {31'd0, key_event}, 32'h1);
    cyc(7);
    RST = 1'b1;
    cyc(1);
    check_eq("midrst_row_out", {28'd0, row_out}, 32'h0000_000E);
    check_eq("midrst_onehot", {16'd0, onehot}, 32'h0);
    check_eq("midrst_valid", {31'd0, key_valid}, 32'h0);
    check_eq("midrst_event", {31'd0, key_event}, 32'h0);
    RST = 1'b0;
    frames(2);
    check_eq("rerst_early", {16'd0, onehot}, 32'h0);
    frames(1);
    check_eq("rerst_onehot", {16'd0, onehot}, 32'h4000);
    check_eq("rerst_event", {31'd0, key_event}, 32'h1);

    // Direct change to (3,3) and hold: repeat pulses only when enabled
    keys = 16'h8000;
    cyc(1);
    ev_base = ev_cnt;
    cyc(15);
    for (int n = 4; n < 24; n++) begin
      exp_oh = (n < 6) ? 16'h4000 : 16'h8000;
      if (REP_EN) exp_ev = (n >= 6) && ((n - 6) % 4 == 0);
      else        exp_ev = (n == 6);
      check_eq("hold_onehot", {16'd0, onehot}, {16'd0, exp_oh});
      check_eq("hold_event", {31'd0, key_event}, {31'd0, exp_ev});
      frames(1);
    end
    exp_rep = REP_EN ? 5 : 1;
    check_eq("hold_events", ev_cnt - ev_base, exp_rep);
    check_eq("hold_valid", {31'd0, key_valid}, 32'h1);
    check_eq("no_double_pulse", {31'd0, dbl_seen}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keypad_scan_encoder.md
# keypad_scan_encoder

- Scans a 4x4 active-low matrix keypad and debounces it.
- Drives the 16-bit one-hot key code consumed by the keypad decoder / password-lock logic, so it is the producer end of the one-hot key bus.
- Output holds one bit for the single pressed key, or all-zero when no key (or more than one key) is pressed.
- Sits between the board keypad pins and the decoder; all logic runs in the single system clock domain.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each row is driven; must be >= 4.
- DEBOUNCE_SCANS, 5: consecutive identical full frames required before `onehot` changes; must be >= 1.
- REPEAT_FRAMES, 125: frames between repeat events (used only with `KEYSCAN_REPEAT_EN`).

Ports:
- clk  in  1  system clock.
- RST  in  1  reset; synchronous and active-high.
- col_in  in  4  keypad column lines, active-low, externally pulled up, asynchronous.
- row_out  out  4  row drive, active-low; exactly one bit is low at any time.
- onehot  out  16  debounced key code. Bit index = 4*row + col. Example: row 1, col 3 gives 16'h0080.
- key_valid  out  1  high while `onehot` is non-zero.
- key_event  out  1  one-cycle pulse whenever `onehot` changes to a non-zero value.

## Operation
- Synchronizer: `col_in` passes through a 2-flop synchronizer before use.
- Row scan:
  - Row index r runs 0..3 and wraps; `row_out` = ~(1<<r).
  - Dwell counter runs 0..SCAN_DIV-1 per row.
  - On the dwell count SCAN_DIV-1, snapshot bits [4r+3:4r] <= ~synced_col. Row index then advances.
- Frame end: the sampling cycle of row 3. On that cycle a candidate code is formed from the completed snapshot:
  - popcount 0 gives candidate 0;
  - popcount 1 gives the snapshot itself;
  - popcount >= 2 gives candidate 0 (multi-press / ghosting rejected).
- Debounce, evaluated once per frame end:
  - If candidate == prev_candidate, stable_cnt increments, saturating at DEBOUNCE_SCANS. Otherwise stable_cnt <= 1.
  - prev_candidate <= candidate.
  - When the new stable_cnt >= DEBOUNCE_SCANS and candidate != onehot: `onehot` <= candidate.
  - If that candidate is non-zero, `key_event` pulses.
- Key changes:
  - Moving directly from key A to key B, without an all-zero stable period, updates `onehot` A to B and pulses `key_event`.
  - Release (candidate 0) updates `onehot` to 0 and does not pulse `key_event`.
- `key_valid` is registered together with `onehot` (equal to `onehot != 0`).

## Timing
- Reset values: `row_out` = 4'b1110, `onehot` = 0, `key_valid` = 0, `key_event` = 0. The dwell counter, row index, snapshot, prev_candidate and stable_cnt are all 0.
- Frame length is 4*SCAN_DIV cycles. `onehot`, `key_valid` and `key_event` update on the clock edge that follows the frame-end sampling cycle.
- Press latency: a key that is stably pressed from the first sample of a frame appears after DEBOUNCE_SCANS frames. A press starting mid-frame may take one additional frame.
- Sampling is SCAN_DIV-1 cycles after the row switch, so the row has settled and the 2-cycle synchronizer has propagated.
- RST asserted mid-scan or mid-debounce restores every reset value on the next edge. Scanning restarts at row 0, dwell 0.
- `key_event` is never high for two consecutive cycles.

## Configuration
- `KEYSCAN_REPEAT_EN` defined:
  - While `onehot` is non-zero and unchanged, a repeat counter counts frame ends.
  - Every REPEAT_FRAMES frames, `key_event` pulses again; `onehot` is held steady.
  - The counter clears whenever `onehot` changes, and on reset.
- `KEYSCAN_REPEAT_EN` undefined:
  - No repeat counter.
  - `key_event` pulses only on a change to a non-zero code.

## Test plan
Common bench setup: SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_FRAMES=4, giving a 16-cycle frame. The keypad model pulls col c low while row r is driven low and key (r,c) is pressed.
- Reset check: hold RST 3 cycles, then scan idle -> `row_out` walks 1110, 1101, 1011, 0111, each for 4 cycles; `onehot` = 0, `key_valid` = 0.
- Single press: press (1,3) aligned to a frame start -> `onehot` = 16'h0080 and `key_valid` = 1 after frame 3. `key_event` is exactly one pulse.
- Release and key change:
  - release (1,3) -> `onehot` returns to 0 after 3 frames with no `key_event`;
  - press (2,1) -> 16'h0200 with one pulse.
- Bounce rejection: toggle (0,0) on alternating frames for 10 frames -> `onehot` stays 0 and no `key_event`.
- Multi-press and reset:
  - press (0,1) and (3,2) together -> `onehot` stays 0;
  - assert RST while 16'h4000 is held -> all outputs return to reset values the next cycle, and the key reappears 3 frames after reset release.
- Repeat with `KEYSCAN_REPEAT_EN` defined: hold (3,3) for 20 frames -> `onehot` = 16'h8000 held. `key_event` pulses at the initial detect, then every 4 frames.
